// File: rtl/sram_stream_dma.sv
// rtl/sram_stream_dma.sv - stream<->SRAM s2-port DMA engine; SRAM_DMA_CHECKSUM_EN adds a checksum output
module sram_stream_dma #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    output logic                busy,
    output logic                done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ADDR_W-1:0]   sram_address,
    output logic                sram_chipselect,
    output logic                sram_write,
    output logic [DATA_W/8-1:0] sram_byteenable,
    output logic [DATA_W-1:0]   sram_writedata,
    output logic                sram_clken,
    input  logic [DATA_W-1:0]   sram_readdata
`ifdef SRAM_DMA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   checksum
`endif
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, FIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [LEN_W-1:0]    remaining;
    logic                inflight;
    logic [DATA_W-1:0]   fifo_mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_count;

    logic [LEN_W-1:0]    len_eff;
    logic                wr_beat;
    logic                rd_issue;
    logic [1:0]          occ;
    logic                pop;
    logic                pop_fifo;
    logic                push;
    logic [DATA_W-1:0]   head;

    // Oversized lengths are clipped to a whole-memory transfer.
    assign len_eff  = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

    // Words buffered or about to arrive; a new read is allowed only if a slot is free for it.
    assign occ      = fifo_count + {1'b0, inflight};
    assign in_ready = (state == WR) && (remaining != '0);
    assign wr_beat  = in_ready && in_valid;
    assign rd_issue = (state == RD) && (remaining != '0) && (occ < 2'd2);

    // With the FIFO empty the returning read word is bypassed straight to the output,
    // giving a one-cycle issue-to-valid latency.
    assign head      = (fifo_count != 2'd0) ? fifo_mem[rd_ptr] : sram_readdata;
    assign out_valid = (fifo_count != 2'd0) || inflight;
    assign out_data  = out_valid ? head : '0;
    assign pop       = out_valid && out_ready;
    assign pop_fifo  = pop && (fifo_count != 2'd0);
    assign push      = inflight && !(pop && (fifo_count == 2'd0));

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == WR) || (state == RD) || (state == DRAIN);
    assign done      = (state == FIN);

    assign sram_chipselect = wr_beat || rd_issue;
    assign sram_write      = wr_beat;
    assign sram_address    = addr_cnt;
    assign sram_writedata  = wr_beat ? in_data : '0;
    assign sram_byteenable = '1;
    assign sram_clken      = 1'b1;

    // Transfer sequencing, address/length counters and output FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr_cnt    <= '0;
            remaining   <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            inflight   <= rd_issue;
            if (push) begin
                fifo_mem[wr_ptr] <= sram_readdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_fifo) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop_fifo};

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_cnt  <= cmd_addr;
                        remaining <= len_eff;
                        if (len_eff == '0) begin
                            state <= FIN;
                        end else begin
                            state <= cmd_dir ? RD : WR;
                        end
                    end
                end
                WR: begin
                    if (wr_beat) begin
                        addr_cnt  <= addr_cnt + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state <= FIN;
                        end
                    end
                end
                RD: begin
                    if (rd_issue) begin
                        addr_cnt  <= addr_cnt + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight && (fifo_count == 2'd0)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_DMA_CHECKSUM_EN
    // Running sum of every word written or delivered, restarted on each accepted command.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (cmd_valid && cmd_ready) begin
            checksum <= '0;
        end else if (wr_beat) begin
            checksum <= checksum + in_data;
        end else if (pop) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule
